// File: rtl/pxs_pkg.sv
// Shared definitions for the pixel-stream text console blocks.
package pxs_pkg;

    // Pixel stream layout
    localparam int unsigned PX_W       = 26;
    localparam int unsigned PX_ACTIVE  = 0;
    localparam int unsigned PX_VS      = 1;
    localparam int unsigned PX_HS      = 2;
    localparam int unsigned PX_YC_LSB  = 3;
    localparam int unsigned PX_YC_MSB  = 12;
    localparam int unsigned PX_XC_LSB  = 13;
    localparam int unsigned PX_XC_MSB  = 22;
    localparam int unsigned PX_RGB_LSB = 23;
    localparam int unsigned PX_RGB_MSB = 25;

    // Cursor command opcodes
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SET     = 3'd1;
    localparam logic [2:0] OP_RIGHT   = 3'd2;
    localparam logic [2:0] OP_LEFT    = 3'd3;
    localparam logic [2:0] OP_UP      = 3'd4;
    localparam logic [2:0] OP_DOWN    = 3'd5;
    localparam logic [2:0] OP_NEWLINE = 3'd6;
    localparam logic [2:0] OP_STYLE   = 3'd7;

    // tcursor bit positions
    localparam int unsigned TC_EN        = 0;
    localparam int unsigned TC_BLINK     = 1;
    localparam int unsigned TC_SHAPE_LSB = 2;
    localparam int unsigned TC_SHAPE_MSB = 3;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StApply
    } cursor_state_e;

endpackage

// File: rtl/pxs_frame_tick.sv
// Frame tick: one-cycle pulse on the rising edge of VS in the pixel stream.
module pxs_frame_tick
    import pxs_pkg::*;
(
    input  logic            px_clk,
    input  logic            reset_n,
    input  logic [PX_W-1:0] RGBStr_i,
    output logic            tick
);

    logic vs_q;
    logic unused_stream;

    // Only VS matters here; the rest of the stream is deliberately ignored.
    assign unused_stream = ^{RGBStr_i[PX_W-1:PX_VS+1], RGBStr_i[PX_ACTIVE]};

    // Remember last cycle's VS for edge detection.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= RGBStr_i[PX_VS];
        end
    end

    assign tick = RGBStr_i[PX_VS] & ~vs_q;

endmodule

// File: rtl/pxs_cursor_ctrl.sv
// Text cursor controller: frame-synchronous position/style updates and blink phase.
module pxs_cursor_ctrl
    import pxs_pkg::*;
#(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 50,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned SYNC_UPDATE  = 1
) (
    input  logic            px_clk,
    input  logic            reset_n,
    input  logic [PX_W-1:0] RGBStr_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [6:0]      cmd_x,
    input  logic [6:0]      cmd_y,
    output logic [6:0]      pos_x,
    output logic [6:0]      pos_y,
    output logic [3:0]      tcursor,
    output logic            scroll_req
);

    localparam logic [6:0]      XMax   = 7'(COLS - 1);
    localparam logic [6:0]      YMax   = 7'(ROWS - 1);
    localparam int unsigned     CntW   = $clog2(BLINK_FRAMES);
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_FRAMES - 1);

    cursor_state_e   state_q;
    logic [2:0]      op_q;
    logic [6:0]      arg_x_q, arg_y_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            blink_en_q, blink_en_d;
    logic            tick;
    logic            apply, is_move;
    logic [6:0]      mv_x, mv_y;
    logic            mv_scroll;

    pxs_frame_tick u_frame_tick (
        .px_clk   (px_clk),
        .reset_n  (reset_n),
        .RGBStr_i (RGBStr_i),
        .tick     (tick)
    );

    assign apply   = (state_q == StApply);
    assign is_move = (op_q != OP_NOP) && (op_q != OP_STYLE);

    // Candidate cursor position for the latched op; compares only, no modulo.
    always_comb begin
        mv_x      = pos_x;
        mv_y      = pos_y;
        mv_scroll = 1'b0;
        case (op_q)
            OP_SET: begin
                mv_x = (arg_x_q > XMax) ? XMax : arg_x_q;
                mv_y = (arg_y_q > YMax) ? YMax : arg_y_q;
            end
            OP_RIGHT: begin
                if (pos_x == XMax) begin
                    mv_x = '0;
                    if (pos_y == YMax) mv_scroll = 1'b1;
                    else               mv_y = pos_y + 7'd1;
                end else begin
                    mv_x = pos_x + 7'd1;
                end
            end
            OP_LEFT: begin
                if (pos_x != '0) begin
                    mv_x = pos_x - 7'd1;
                end else if (pos_y != '0) begin
                    mv_x = XMax;
                    mv_y = pos_y - 7'd1;
                end
            end
            OP_UP: begin
                if (pos_y != '0) mv_y = pos_y - 7'd1;
            end
            OP_DOWN: begin
                if (pos_y == YMax) mv_scroll = 1'b1;
                else               mv_y = pos_y + 7'd1;
            end
            OP_NEWLINE: begin
                mv_x = '0;
                if (pos_y == YMax) mv_scroll = 1'b1;
                else               mv_y = pos_y + 7'd1;
            end
            default: ;
        endcase
    end

    // Blink counter/phase next state; an applied move overrides a coincident wrap.
    always_comb begin
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        blink_en_d = blink_en_q;
        if (tick) begin
            if (cnt_q == CntMax) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        if (apply && is_move) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
        if (apply && (op_q == OP_STYLE)) begin
            blink_en_d = arg_x_q[1];
        end
    end

    // Blink state registers.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            blink_en_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            blink_en_q <= blink_en_d;
        end
    end

    // Command FSM with registered outputs.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cmd_ready  <= 1'b1;
            op_q       <= OP_NOP;
            arg_x_q    <= '0;
            arg_y_q    <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            tcursor    <= 4'b0001;
            scroll_req <= 1'b0;
        end else begin
            scroll_req         <= 1'b0;
            tcursor[TC_BLINK]  <= phase_d & blink_en_d;
            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        arg_x_q   <= cmd_x;
                        arg_y_q   <= cmd_y;
                        cmd_ready <= 1'b0;
                        state_q   <= (SYNC_UPDATE != 0) ? StPend : StApply;
                    end
                end
                StPend: begin
                    if (tick) state_q <= StApply;
                end
                StApply: begin
                    if (is_move) begin
                        pos_x      <= mv_x;
                        pos_y      <= mv_y;
                        scroll_req <= mv_scroll;
                    end
                    if (op_q == OP_STYLE) begin
                        tcursor[TC_EN]                     <= arg_x_q[0];
                        tcursor[TC_SHAPE_MSB:TC_SHAPE_LSB] <= arg_x_q[3:2];
                    end
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pxs_cursor_ctrl.sv
// Scoreboard bench for pxs_cursor_ctrl: expected output snapshots are queued by
// the stimulus, a negedge monitor pops one on every observed output change.
module tb_pxs_cursor_ctrl;

    localparam logic [2:0] OP_SET     = 3'd1;
    localparam logic [2:0] OP_RIGHT   = 3'd2;
    localparam logic [2:0] OP_LEFT    = 3'd3;
    localparam logic [2:0] OP_UP      = 3'd4;
    localparam logic [2:0] OP_DOWN    = 3'd5;
    localparam logic [2:0] OP_NEWLINE = 3'd6;
    localparam logic [2:0] OP_STYLE   = 3'd7;

    logic        px_clk    = 1'b0;
    logic        reset_n   = 1'b1;
    logic [25:0] rgb       = '0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op    = '0;
    logic [6:0]  cmd_x     = '0;
    logic [6:0]  cmd_y     = '0;
    logic        cmd_ready;
    logic [6:0]  pos_x, pos_y;
    logic [3:0]  tcursor;
    logic        scroll_req;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic [3:0] tc;
        logic       scr;
    } snap_t;

    snap_t exp_q[$];
    int    exp_cyc_q[$];
    string exp_name_q[$];
    snap_t prev;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    pxs_cursor_ctrl #(
        .COLS         (80),
        .ROWS         (50),
        .BLINK_FRAMES (16),
        .SYNC_UPDATE  (1)
    ) dut (
        .px_clk     (px_clk),
        .reset_n    (reset_n),
        .RGBStr_i   (rgb),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .tcursor    (tcursor),
        .scroll_req (scroll_req)
    );

    always #5 px_clk = ~px_clk;
    always @(posedge px_clk) cyc <= cyc + 1;

    // Monitor: every change of the output set must match the next queued snapshot.
    always @(negedge px_clk) begin
        snap_t cur;
        snap_t e;
        int    ec;
        string nm;
        cur = {pos_x, pos_y, tcursor, scroll_req};
        if (cur !== prev) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got x=%0d y=%0d tc=%b scroll=%b at cycle %0d, required no change",
                         cur.x, cur.y, cur.tc, cur.scr, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                nm = exp_name_q.pop_front();
                if (cur !== e || (ec >= 0 && cyc != ec)) begin
                    n_fail++;
                    $display("FAIL %s: got x=%0d y=%0d tc=%b scroll=%b at cycle %0d, required x=%0d y=%0d tc=%b scroll=%b at cycle %0d",
                             nm, cur.x, cur.y, cur.tc, cur.scr, cyc, e.x, e.y, e.tc, e.scr, ec);
                end
            end
            prev = cur;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    task automatic push(input string nm, input logic [6:0] x, input logic [6:0] y,
                        input logic [3:0] tc, input logic scr, input int ec);
        snap_t s;
        s = {x, y, tc, scr};
        exp_q.push_back(s);
        exp_cyc_q.push_back(ec);
        exp_name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge px_clk);
        #1;
    endtask

    // Offer one command; optionally raise VS in the accepting cycle.
    task automatic send(input string nm, input logic [2:0] op, input logic [6:0] x,
                        input logic [6:0] y, input bit with_vs);
        int waited = 0;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 50) begin
            step(1);
            waited++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: cmd_ready stayed 0 for %0d cycles, required 1", nm, waited);
        end
        if (with_vs) rgb[1] = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        rgb[1]    = 1'b0;
        check({nm, "_ready_drop"}, cmd_ready, 0);
    endtask

    // One-cycle VS pulse followed by two low cycles (tick in the first cycle).
    task automatic vs_pulse(input bit chk);
        rgb[1] = 1'b1;
        step(1);
        rgb[1] = 1'b0;
        if (chk) check("ready_in_apply", cmd_ready, 0);
        step(1);
        if (chk) check("ready_after_apply", cmd_ready, 1);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with VS low
        #2 reset_n = 1'b0;
        push("reset_state", 7'd0, 7'd0, 4'b0001, 1'b0, -1);
        step(3);
        check("reset_ready", cmd_ready, 1);
        check("reset_scroll", scroll_req, 0);
        reset_n = 1'b1;
        step(2);

        // SET clamps to the last cell; ready held low while pending
        send("set_clamp", OP_SET, 7'd85, 7'd60, 1'b0);
        step(3);
        check("set_pend_ready", cmd_ready, 0);
        push("set_clamp", 7'd79, 7'd49, 4'b0001, 1'b0, cyc + 2);
        vs_pulse(1'b1);

        // RIGHT at the last cell wraps to column 0 and scrolls for one cycle
        send("right_last", OP_RIGHT, 7'd0, 7'd0, 1'b0);
        push("right_scroll", 7'd0, 7'd49, 4'b0001, 1'b1, cyc + 2);
        push("right_scroll_end", 7'd0, 7'd49, 4'b0001, 1'b0, cyc + 3);
        vs_pulse(1'b1);

        // A tick in the accepting cycle is ignored; the next frame applies
        send("set_coincide", OP_SET, 7'd3, 7'd4, 1'b1);
        step(4);
        check("coincide_still_pend", cmd_ready, 0);
        push("set_coincide", 7'd3, 7'd4, 4'b0001, 1'b0, cyc + 2);
        vs_pulse(1'b1);

        // LEFT and UP at the origin change nothing and never scroll
        send("set_origin", OP_SET, 7'd0, 7'd0, 1'b0);
        push("set_origin", 7'd0, 7'd0, 4'b0001, 1'b0, cyc + 2);
        vs_pulse(1'b1);
        send("left_origin", OP_LEFT, 7'd0, 7'd0, 1'b0);
        vs_pulse(1'b1);
        send("up_origin", OP_UP, 7'd0, 7'd0, 1'b0);
        vs_pulse(1'b1);

        // LEFT at column 0 wraps to the previous row
        send("set_0_5", OP_SET, 7'd0, 7'd5, 1'b0);
        push("set_0_5", 7'd0, 7'd5, 4'b0001, 1'b0, cyc + 2);
        vs_pulse(1'b1);
        send("left_wrap", OP_LEFT, 7'd0, 7'd0, 1'b0);
        push("left_wrap", 7'd79, 7'd4, 4'b0001, 1'b0, cyc + 2);
        vs_pulse(1'b1);

        // STYLE 1011: enabled, blinking, shape 10; its own tick is frame 1
        send("style", OP_STYLE, 7'b0001011, 7'd0, 1'b0);
        push("style", 7'd79, 7'd4, 4'b1001, 1'b0, cyc + 2);
        vs_pulse(1'b1);
        for (int t = 2; t <= 48; t++) begin
            if (t == 16 || t == 48) push("blink_hide", 7'd79, 7'd4, 4'b1011, 1'b0, cyc + 1);
            else if (t == 32)       push("blink_show", 7'd79, 7'd4, 4'b1001, 1'b0, cyc + 1);
            vs_pulse(1'b0);
        end

        // Hidden, counter at 5: DOWN clears phase and counter
        repeat (5) vs_pulse(1'b0);
        send("down_clear", OP_DOWN, 7'd0, 7'd0, 1'b0);
        push("down_clear", 7'd79, 7'd5, 4'b1001, 1'b0, cyc + 2);
        vs_pulse(1'b1);
        for (int t = 1; t <= 16; t++) begin
            if (t == 16) push("blink_after_clear", 7'd79, 7'd5, 4'b1011, 1'b0, cyc + 1);
            vs_pulse(1'b0);
        end

        // Hidden, counter at 15: DOWN lands on a wrap frame
        repeat (15) vs_pulse(1'b0);
        send("down_on_wrap", OP_DOWN, 7'd0, 7'd0, 1'b0);
        push("wrap_phase", 7'd79, 7'd5, 4'b1001, 1'b0, cyc + 1);
        push("down_on_wrap", 7'd79, 7'd6, 4'b1001, 1'b0, cyc + 2);
        vs_pulse(1'b1);
        for (int t = 1; t <= 16; t++) begin
            if (t == 16) push("blink_after_wrap", 7'd79, 7'd6, 4'b1011, 1'b0, cyc + 1);
            vs_pulse(1'b0);
        end

        // Bottom row: NEWLINE and DOWN both scroll
        send("set_bottom", OP_SET, 7'd10, 7'd49, 1'b0);
        push("set_bottom", 7'd10, 7'd49, 4'b1001, 1'b0, cyc + 2);
        vs_pulse(1'b1);
        send("newline_bottom", OP_NEWLINE, 7'd0, 7'd0, 1'b0);
        push("newline_scroll", 7'd0, 7'd49, 4'b1001, 1'b1, cyc + 2);
        push("newline_scroll_end", 7'd0, 7'd49, 4'b1001, 1'b0, cyc + 3);
        vs_pulse(1'b1);
        send("down_bottom", OP_DOWN, 7'd0, 7'd0, 1'b0);
        push("down_scroll", 7'd0, 7'd49, 4'b1001, 1'b1, cyc + 2);
        push("down_scroll_end", 7'd0, 7'd49, 4'b1001, 1'b0, cyc + 3);
        vs_pulse(1'b1);

        // Asynchronous reset while a SET is pending discards it
        send("set_then_reset", OP_SET, 7'd20, 7'd20, 1'b0);
        step(2);
        check("pending_ready", cmd_ready, 0);
        #1 reset_n = 1'b0;
        push("async_reset", 7'd0, 7'd0, 4'b0001, 1'b0, -1);
        #1;
        check("reset_imm_pos", {pos_x, pos_y}, 0);
        check("reset_imm_tc", tcursor, 4'b0001);
        check("reset_imm_ready", cmd_ready, 1);
        step(2);
        reset_n = 1'b1;
        step(1);
        repeat (3) vs_pulse(1'b0);
        check("ready_after_reset", cmd_ready, 1);

        step(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
